trim_code_sel: RTL and testbench

Trim-code source and frame sequencer that sits directly upstream of the trim serializer. It presents a stable 12-bit trim code to the serializer and holds its START request until the serializer begins shifting. It then counts the ENCLK pulses of the frame to detect completion. It runs in two modes: a single manual load from switches, or an automatic sweep across a code range with a settle dwell after each frame.

---
 rtl/trim_code_sel.sv | 190 +++++++++++++++++++
 tb/tb_trim_code_sel.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trim_code_sel.sv
// Trim-code source and frame sequencer feeding the trim serializer (manual load or code sweep).
// Define TRIM_SWEEP_WRAP_EN to make a sweep wrap from CODE_MAX back to CODE_MIN instead of ending.
`timescale 1ns/1ps

module trim_code_sel #(
    parameter logic [11:0] RESET_CODE  = 12'h7BF,
    parameter logic [11:0] CODE_MIN    = 12'h000,
    parameter logic [11:0] CODE_MAX    = 12'hFFF,
    parameter int unsigned FRAME_EDGES = 14,
    parameter int unsigned DWELL_CYC   = 50_000_000,
    parameter int unsigned TIMEOUT_CYC = 250_000_000
) (
    input  logic        CLOCK_50,
    input  logic        RST,
    input  logic        GO,
    input  logic        MODE,
    input  logic [11:0] SW,
    input  logic        ENCLK,
    output logic [11:0] TRIM_CODE,
    output logic        START,
    output logic        BUSY,
    output logic        FRAME_DONE,
    output logic        ERR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SHIFT,
        S_DWELL
    } state_t;

    localparam logic [4:0]  EDGE_LAST  = 5'(FRAME_EDGES - 1);
    localparam logic [27:0] DWELL_LAST = 28'(DWELL_CYC - 1);
    localparam logic [27:0] TMO_LAST   = 28'(TIMEOUT_CYC - 1);

    logic        go_meta, go_sync, go_prev, go_rise;
    logic        enclk_meta, enclk_sync, enclk_prev, enclk_rise;
    logic        mode_meta, mode_sync;
    logic [11:0] sw_meta, sw_sync;

    state_t      state;
    logic [11:0] trim_code;
    logic        start, busy, frame_done, err;
    logic        sweep, stop_pend;
    logic [4:0]  edge_cnt;
    logic [27:0] tmo_cnt;
    logic [27:0] dwell_cnt;

    // Edge pulses are registered so every pin-to-output path is a fixed 4 cycles.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            go_meta    <= 1'b0;
            go_sync    <= 1'b0;
            go_prev    <= 1'b0;
            go_rise    <= 1'b0;
            enclk_meta <= 1'b0;
            enclk_sync <= 1'b0;
            enclk_prev <= 1'b0;
            enclk_rise <= 1'b0;
            mode_meta  <= 1'b0;
            mode_sync  <= 1'b0;
            sw_meta    <= 12'h000;
            sw_sync    <= 12'h000;
        end else begin
            go_meta    <= GO;
            go_sync    <= go_meta;
            go_prev    <= go_sync;
            go_rise    <= go_sync & ~go_prev;
            enclk_meta <= ENCLK;
            enclk_sync <= enclk_meta;
            enclk_prev <= enclk_sync;
            enclk_rise <= enclk_sync & ~enclk_prev;
            mode_meta  <= MODE;
            mode_sync  <= mode_meta;
            sw_meta    <= SW;
            sw_sync    <= sw_meta;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            trim_code  <= RESET_CODE;
            start      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            sweep      <= 1'b0;
            stop_pend  <= 1'b0;
            edge_cnt   <= 5'd0;
            tmo_cnt    <= 28'd0;
            dwell_cnt  <= 28'd0;
        end else begin
            frame_done <= 1'b0;
            if (state != S_IDLE && go_rise && sweep) begin
                stop_pend <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (go_rise) begin
                        trim_code <= mode_sync ? CODE_MIN : sw_sync;
                        sweep     <= mode_sync;
                        stop_pend <= 1'b0;
                        err       <= 1'b0;
                        tmo_cnt   <= 28'd0;
                        start     <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (enclk_rise) begin
                        start    <= 1'b0;
                        edge_cnt <= 5'd1;
                        tmo_cnt  <= 28'd0;
                        state    <= S_SHIFT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err   <= 1'b1;
                        start <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 28'd1;
                    end
                end
                S_SHIFT: begin
                    if (enclk_rise) begin
                        tmo_cnt  <= 28'd0;
                        edge_cnt <= edge_cnt + 5'd1;
                        if (edge_cnt == EDGE_LAST) begin
                            frame_done <= 1'b1;
                            dwell_cnt  <= 28'd0;
                            if (sweep) begin
                                state <= S_DWELL;
                            end else begin
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        err   <= 1'b1;
                        start <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 28'd1;
                    end
                end
                S_DWELL: begin
                    if (dwell_cnt != DWELL_LAST) begin
                        dwell_cnt <= dwell_cnt + 28'd1;
                    end else if (stop_pend || (go_rise && sweep)) begin
                        stop_pend <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (trim_code < CODE_MAX) begin
                        trim_code <= trim_code + 12'd1;
                        tmo_cnt   <= 28'd0;
                        start     <= 1'b1;
                        state     <= S_REQ;
                    end else begin
`ifdef TRIM_SWEEP_WRAP_EN
                        trim_code <= CODE_MIN;
                        tmo_cnt   <= 28'd0;
                        start     <= 1'b1;
                        state     <= S_REQ;
`else
                        stop_pend <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
`endif
                    end
                end
                default: begin
                    start <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign TRIM_CODE  = trim_code;
    assign START      = start;
    assign BUSY       = busy;
    assign FRAME_DONE = frame_done;
    assign ERR        = err;

endmodule

// File: tb/tb_trim_code_sel.sv
// Scoreboard bench for trim_code_sel: expected codes are queued at stimulus time and
// popped by a monitor on each START rise and FRAME_DONE pulse.
`timescale 1ns/1ps

module tb_trim_code_sel;

    logic        CLOCK_50 = 1'b0;
    logic        RST      = 1'b1;
    logic        GO       = 1'b0;
    logic        MODE     = 1'b0;
    logic [11:0] SW       = 12'h000;
    logic        ENCLK    = 1'b0;
    logic [11:0] TRIM_CODE;
    logic        START, BUSY, FRAME_DONE, ERR;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [11:0] start_q[$];
    logic [11:0] done_q[$];
    logic        start_prev = 1'b0;
    logic        done_prev  = 1'b0;
    int          n;

    trim_code_sel #(
        .RESET_CODE (12'h7BF),
        .CODE_MIN   (12'h00E),
        .CODE_MAX   (12'h010),
        .FRAME_EDGES(14),
        .DWELL_CYC  (20),
        .TIMEOUT_CYC(200)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RST       (RST),
        .GO        (GO),
        .MODE      (MODE),
        .SW        (SW),
        .ENCLK     (ENCLK),
        .TRIM_CODE (TRIM_CODE),
        .START     (START),
        .BUSY      (BUSY),
        .FRAME_DONE(FRAME_DONE),
        .ERR       (ERR)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(negedge CLOCK_50);
    endtask

    task automatic enclkPulse();
        ENCLK = 1'b1;
        tick(2);
        ENCLK = 1'b0;
        tick(2);
    endtask

    // Sets mode/switches, lets them synchronize, then pulses GO; START is already up on return.
    task automatic applyStimulus(input logic mode, input logic [11:0] sw);
        MODE = mode;
        SW   = sw;
        tick(3);
        GO = 1'b1;
        tick(3);
        GO = 1'b0;
        tick(2);
    endtask

    task automatic serveFrame(input bit stop_mid);
        int wait_n;
        wait_n = 0;
        while (START !== 1'b1 && wait_n < 400) begin
            tick(1);
            wait_n++;
        end
        checkOutput("frame_start_seen", START, 1);
        if (stop_mid) begin
            GO = 1'b1;
            tick(3);
            GO = 1'b0;
            tick(2);
        end
        for (int i = 0; i < 14; i++) enclkPulse();
        checkOutput("frame_done_at_end", FRAME_DONE, 1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a new request or a completed frame.
    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (!RST) begin
                if (START && !start_prev) begin
                    if (start_q.size() == 0) checkOutput("start_queue_nonempty", start_q.size(), 1);
                    else checkOutput("start_code", TRIM_CODE, start_q.pop_front());
                end
                if (FRAME_DONE) begin
                    checkOutput("done_single_cycle", done_prev, 0);
                    if (done_q.size() == 0) checkOutput("done_queue_nonempty", done_q.size(), 1);
                    else checkOutput("done_code", TRIM_CODE, done_q.pop_front());
                end
            end
            start_prev = START;
            done_prev  = FRAME_DONE;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values
        tick(3);
        checkOutput("rst_trim_code", TRIM_CODE, 12'h7BF);
        checkOutput("rst_start", START, 0);
        checkOutput("rst_busy", BUSY, 0);
        checkOutput("rst_err", ERR, 0);
        checkOutput("rst_frame_done", FRAME_DONE, 0);
        RST = 1'b0;
        tick(2);

        // Manual load with exact latencies
        start_q.push_back(12'h123);
        done_q.push_back(12'h123);
        MODE = 1'b0;
        SW   = 12'h123;
        tick(3);
        GO = 1'b1;
        tick(3);
        checkOutput("start_not_early", START, 0);
        tick(1);
        checkOutput("start_latency", START, 1);
        checkOutput("busy_in_req", BUSY, 1);
        GO = 1'b0;
        ENCLK = 1'b1;
        tick(2);
        ENCLK = 1'b0;
        tick(1);
        checkOutput("start_held", START, 1);
        tick(1);
        checkOutput("start_drop_latency", START, 0);
        checkOutput("code_stable_shift", TRIM_CODE, 12'h123);
        for (int i = 0; i < 12; i++) enclkPulse();
        ENCLK = 1'b1;
        tick(2);
        ENCLK = 1'b0;
        tick(1);
        checkOutput("done_not_early", FRAME_DONE, 0);
        tick(1);
        checkOutput("done_latency", FRAME_DONE, 1);
        checkOutput("manual_idle", BUSY, 0);
        tick(1);
        checkOutput("done_cleared", FRAME_DONE, 0);
        checkOutput("manual_code_held", TRIM_CODE, 12'h123);
        tick(5);

`ifdef TRIM_SWEEP_WRAP_EN
        // Sweep with wrap, stopped by GO during the fourth frame
        start_q.push_back(12'h00E); done_q.push_back(12'h00E);
        start_q.push_back(12'h00F); done_q.push_back(12'h00F);
        start_q.push_back(12'h010); done_q.push_back(12'h010);
        start_q.push_back(12'h00E); done_q.push_back(12'h00E);
        applyStimulus(1'b1, 12'h555);
        serveFrame(1'b0);
        serveFrame(1'b0);
        serveFrame(1'b0);
        serveFrame(1'b1);
        tick(10);
        checkOutput("stop_dwell_busy", BUSY, 1);
        checkOutput("stop_dwell_no_start", START, 0);
        n = 0;
        while (BUSY !== 1'b0 && n < 100) begin
            tick(1);
            n++;
        end
        checkOutput("stop_dwell_len", n, 10);
        checkOutput("stop_code_held", TRIM_CODE, 12'h00E);
`else
        // Sweep without wrap: three codes then idle at CODE_MAX
        start_q.push_back(12'h00E); done_q.push_back(12'h00E);
        start_q.push_back(12'h00F); done_q.push_back(12'h00F);
        start_q.push_back(12'h010); done_q.push_back(12'h010);
        applyStimulus(1'b1, 12'h555);
        serveFrame(1'b0);
        n = 0;
        while (START !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        checkOutput("dwell_len", n, 20);
        serveFrame(1'b0);
        serveFrame(1'b0);
        n = 0;
        while (BUSY !== 1'b0 && n < 100) begin
            tick(1);
            n++;
        end
        checkOutput("final_dwell_len", n, 20);
        checkOutput("sweep_end_code", TRIM_CODE, 12'h010);
        checkOutput("sweep_end_start", START, 0);
`endif
        tick(5);

        // Timeout with ENCLK idle, then recovery on the next GO
        start_q.push_back(12'h0A5);
        MODE = 1'b0;
        SW   = 12'h0A5;
        tick(3);
        GO = 1'b1;
        tick(4);
        checkOutput("tmo_start_up", START, 1);
        GO = 1'b0;
        n = 0;
        while (ERR !== 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        checkOutput("tmo_len", n, 200);
        checkOutput("tmo_err", ERR, 1);
        checkOutput("tmo_start", START, 0);
        checkOutput("tmo_idle", BUSY, 0);
        start_q.push_back(12'h0A5);
        done_q.push_back(12'h0A5);
        tick(3);
        GO = 1'b1;
        tick(4);
        checkOutput("err_cleared", ERR, 0);
        checkOutput("tmo_restart", START, 1);
        GO = 1'b0;
        serveFrame(1'b0);
        tick(5);

        // Reset in the middle of a frame, then a clean frame
        start_q.push_back(12'h3C3);
        applyStimulus(1'b0, 12'h3C3);
        for (int i = 0; i < 5; i++) enclkPulse();
        #3 RST = 1'b1;
        #1;
        checkOutput("midrst_start", START, 0);
        checkOutput("midrst_busy", BUSY, 0);
        checkOutput("midrst_code", TRIM_CODE, 12'h7BF);
        checkOutput("midrst_err", ERR, 0);
        tick(2);
        RST = 1'b0;
        tick(2);
        start_q.push_back(12'h3C3);
        done_q.push_back(12'h3C3);
        applyStimulus(1'b0, 12'h3C3);
        serveFrame(1'b0);
        tick(2);
        checkOutput("post_rst_idle", BUSY, 0);
        checkOutput("post_rst_code", TRIM_CODE, 12'h3C3);

        tick(5);
        checkOutput("start_queue_drained", start_q.size(), 0);
        checkOutput("done_queue_drained", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
